// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: flit width, type-field encoding and framing states.
package noc_flit_pkg;

    localparam int FLIT_W = 64;
    localparam int FT_W   = 2;

    // Flit type lives in the top FT_W bits of each flit.
    localparam int FT_LSB = FLIT_W - FT_W;

    localparam logic [FT_W-1:0] FT_HEAD     = 2'b10;
    localparam logic [FT_W-1:0] FT_BODY     = 2'b00;
    localparam logic [FT_W-1:0] FT_TAIL     = 2'b01;
    localparam logic [FT_W-1:0] FT_HEADTAIL = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    function automatic logic ft_is_sop(input logic [FT_W-1:0] ft);
        return (ft == FT_HEAD) || (ft == FT_HEADTAIL);
    endfunction

    function automatic logic ft_is_eop(input logic [FT_W-1:0] ft);
        return (ft == FT_TAIL) || (ft == FT_HEADTAIL);
    endfunction

endpackage

// File: rtl/fifo_flit_reader_if.sv
// FIFO read port plus the outgoing flit stream of the read-side controller.
interface fifo_flit_reader_if
    import noc_flit_pkg::*;
#(
    parameter int DW = FLIT_W
);

    logic [DW-1:0] rdata;
    logic          rempty;
    logic          rinc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;

    modport master (
        input  rdata, rempty, out_ready,
        output rinc, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        output rdata, rempty, out_ready,
        input  rinc, out_valid, out_data, out_sop, out_eop
    );

endinterface

// File: rtl/flit_skid_buf.sv
// Two-entry strict-FIFO skid buffer carrying a flit with its sop/eop marks.
module flit_skid_buf
    import noc_flit_pkg::*;
#(
    parameter int DW = FLIT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_sop,
    input  logic          push_eop,
    input  logic          pop_ready,
    output logic          head_valid,
    output logic [DW-1:0] head_data,
    output logic          head_sop,
    output logic          head_eop,
    output logic [1:0]    occ
);

    logic [DW+1:0] slot0;
    logic [DW+1:0] slot1;
    logic [DW+1:0] entry_in;
    logic          pop;

    assign entry_in   = {push_sop, push_eop, push_data};
    assign head_valid = (occ != 2'd0);
    assign pop        = head_valid && pop_ready;
    assign head_sop   = slot0[DW+1];
    assign head_eop   = slot0[DW];
    assign head_data  = slot0[DW-1:0];

    // slot0 is always the head; a push lands behind whatever survives the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= entry_in;
                    else             slot1 <= entry_in;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0 <= entry_in;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= entry_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_flit_reader.sv
// Read-side flit FIFO controller: pops flits, checks packet framing, and streams them out via a skid buffer.
module fifo_flit_reader
    import noc_flit_pkg::*;
#(
    parameter int DW    = FLIT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_flit_reader_if.master bus,
    output logic             err_orphan,
    output logic             err_trunc,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t          state;
    state_t          state_nxt;
    logic [FT_W-1:0] ft;
    logic [1:0]      occ;
    logic            fwd;
    logic            orphan;
    logic            trunc;
    logic            pkt_done;

    assign ft       = bus.rdata[DW-1 -: FT_W];
    assign bus.rinc = !rst && !bus.rempty && (occ < 2'd2);

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        orphan    = 1'b0;
        trunc     = 1'b0;
        pkt_done  = 1'b0;
        if (bus.rinc) begin
            case (state)
                IDLE: begin
                    case (ft)
                        FT_HEAD:     begin fwd = 1'b1; state_nxt = IN_PKT; end
                        FT_HEADTAIL: begin fwd = 1'b1; pkt_done = 1'b1; end
                        default:     orphan = 1'b1;
                    endcase
                end
                IN_PKT: begin
                    case (ft)
                        FT_BODY:     fwd = 1'b1;
                        FT_TAIL:     begin fwd = 1'b1; pkt_done = 1'b1; state_nxt = IDLE; end
                        FT_HEAD:     begin fwd = 1'b1; trunc = 1'b1; end
                        FT_HEADTAIL: begin
                            fwd       = 1'b1;
                            trunc     = 1'b1;
                            pkt_done  = 1'b1;
                            state_nxt = IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Packet count wraps; error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            err_orphan <= 1'b0;
            err_trunc  <= 1'b0;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            err_orphan <= orphan;
            err_trunc  <= trunc;
            if (pkt_done) pkt_cnt <= pkt_cnt + CNT_W'(1);
            if ((orphan || trunc) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    flit_skid_buf #(.DW(DW)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (fwd),
        .push_data  (bus.rdata),
        .push_sop   (ft_is_sop(ft)),
        .push_eop   (ft_is_eop(ft)),
        .pop_ready  (bus.out_ready),
        .head_valid (bus.out_valid),
        .head_data  (bus.out_data),
        .head_sop   (bus.out_sop),
        .head_eop   (bus.out_eop),
        .occ        (occ)
    );

endmodule

// File: tb/tb_fifo_flit_reader.sv
// Self-checking bench for fifo_flit_reader: a queue models the FIFO, a packet-level model predicts the stream.
module tb_fifo_flit_reader;

    localparam int DW = 64;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_orphan;
    logic          err_trunc;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q[$];
    ent_t          m_buf[$];
    bit            m_in_pkt;
    int            m_pkt;
    int            m_err;
    bit            exp_orph;
    bit            exp_trunc;

    always #5 clk = ~clk;

    fifo_flit_reader_if #(.DW(DW)) bus ();

    fifo_flit_reader #(.DW(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_orphan (err_orphan),
        .err_trunc  (err_trunc),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    function automatic logic [DW-1:0] mk_flit(input logic [1:0] t, input logic [61:0] payload);
        return {t, payload};
    endfunction

    // Packet-level framing rules applied to one popped flit.
    task automatic model_pop(input logic [DW-1:0] f);
        automatic logic [1:0] t = f[DW-1:DW-2];
        automatic bit is_head = (t == 2'b10) || (t == 2'b11);
        automatic bit is_tail = (t == 2'b01) || (t == 2'b11);
        automatic ent_t e;
        if (!m_in_pkt && !is_head) begin
            exp_orph = 1'b1;
        end else begin
            if (m_in_pkt && is_head) exp_trunc = 1'b1;
            e.d = f; e.sop = is_head; e.eop = is_tail;
            m_buf.push_back(e);
            if (is_tail) begin
                m_pkt    = (m_pkt + 1) % (1 << CW);
                m_in_pkt = 1'b0;
            end else begin
                m_in_pkt = 1'b1;
            end
        end
        if ((exp_orph || exp_trunc) && (m_err < (1 << CW) - 1)) m_err++;
    endtask

    task automatic drive_inputs(input bit ready);
        bus.out_ready = ready;
        if (fifo_q.size() > 0) begin
            bus.rempty = 1'b0;
            bus.rdata  = fifo_q[0];
        end else begin
            bus.rempty = 1'b1;
            bus.rdata  = {$urandom, $urandom};
        end
    endtask

    // One clock of stimulus with scoreboard comparison, starting and ending at a negedge.
    task automatic applyStimulus(input bit ready);
        automatic bit exp_rinc;
        automatic bit fire;
        automatic ent_t e;
        drive_inputs(ready);
        #1;
        exp_rinc = (fifo_q.size() > 0) && (m_buf.size() < 2);
        total++;
        if (bus.rinc !== exp_rinc) begin
            bad++;
            $display("[TB] FAIL rinc: got %b expected %b at %0t", bus.rinc, exp_rinc, $time);
        end
        total++;
        if (bus.out_valid !== (m_buf.size() > 0)) begin
            bad++;
            $display("[TB] FAIL out_valid: got %b expected %b at %0t", bus.out_valid, m_buf.size() > 0, $time);
        end
        if (m_buf.size() > 0) begin
            e = m_buf[0];
            total++;
            if ({bus.out_data, bus.out_sop, bus.out_eop} !== {e.d, e.sop, e.eop}) begin
                bad++;
                $display("[TB] FAIL out_flit: got %h sop=%b eop=%b expected %h sop=%b eop=%b at %0t",
                         bus.out_data, bus.out_sop, bus.out_eop, e.d, e.sop, e.eop, $time);
            end
        end
        total++;
        if ({err_orphan, err_trunc} !== {exp_orph, exp_trunc}) begin
            bad++;
            $display("[TB] FAIL err_pulses: got orphan=%b trunc=%b expected orphan=%b trunc=%b at %0t",
                     err_orphan, err_trunc, exp_orph, exp_trunc, $time);
        end
        total++;
        if ((pkt_cnt !== CW'(m_pkt)) || (err_cnt !== CW'(m_err))) begin
            bad++;
            $display("[TB] FAIL counters: got pkt=%0d err=%0d expected pkt=%0d err=%0d at %0t",
                     pkt_cnt, err_cnt, m_pkt, m_err, $time);
        end
        fire = (m_buf.size() > 0) && ready;
        @(posedge clk);
        exp_orph  = 1'b0;
        exp_trunc = 1'b0;
        if (fire) void'(m_buf.pop_front());
        if (exp_rinc) model_pop(fifo_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_inputs(1'b0);
        #1;
        total++;
        if (bus.rinc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rinc_in_reset: got %b expected 0", bus.rinc);
        end
        @(posedge clk);
        m_buf.delete();
        m_in_pkt  = 1'b0;
        m_pkt     = 0;
        m_err     = 0;
        exp_orph  = 1'b0;
        exp_trunc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.rempty    = 1'b1;
        bus.out_ready = 1'b0;
        bus.rdata     = '0;
        do_reset();
        total++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop, err_orphan, err_trunc} !== 5'b0 || bus.out_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h sop=%b eop=%b eo=%b et=%b expected all 0",
                     bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, err_orphan, err_trunc);
        end
        total++;
        if (pkt_cnt !== '0 || err_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL reset_counters: got pkt=%0d err=%0d expected 0 0", pkt_cnt, err_cnt);
        end
        applyStimulus(1'b1);
    endtask

    task automatic test_headtail();
        fifo_q.push_back(64'hC000_0000_0000_00AA);
        applyStimulus(1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hC000_0000_0000_00AA ||
            bus.out_sop !== 1'b1 || bus.out_eop !== 1'b1 || pkt_cnt !== 4'd1) begin
            bad++;
            $display("[TB] FAIL headtail: got v=%b d=%h s=%b e=%b pkt=%0d expected 1 c0000000000000aa 1 1 1",
                     bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, pkt_cnt);
        end
        repeat (2) applyStimulus(1'b1);
    endtask

    task automatic test_packet();
        fifo_q.push_back(mk_flit(2'b10, 62'h11));
        fifo_q.push_back(mk_flit(2'b00, 62'h22));
        fifo_q.push_back(mk_flit(2'b00, 62'h33));
        fifo_q.push_back(mk_flit(2'b01, 62'h44));
        repeat (6) applyStimulus(1'b1);
        total++;
        if (pkt_cnt !== 4'd2 || err_cnt !== 4'd0) begin
            bad++;
            $display("[TB] FAIL packet_count: got pkt=%0d err=%0d expected 2 0", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back_stall();
        automatic logic [DW-1:0] d0;
        fifo_q.push_back(mk_flit(2'b10, 62'h101));
        for (int i = 0; i < 3; i++) fifo_q.push_back(mk_flit(2'b00, 62'h102 + 62'(i)));
        fifo_q.push_back(mk_flit(2'b01, 62'h105));
        applyStimulus(1'b0);
        d0 = bus.out_data;
        repeat (3) applyStimulus(1'b0);
        total++;
        if (bus.out_data !== d0 || d0 !== mk_flit(2'b10, 62'h101) || bus.rinc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_hold: got data=%h first=%h rinc=%b expected data=%h rinc=0",
                     bus.out_data, d0, bus.rinc, mk_flit(2'b10, 62'h101));
        end
        repeat (8) applyStimulus(1'b1);
        total++;
        if (bus.out_valid !== 1'b0 || pkt_cnt !== 4'd3) begin
            bad++;
            $display("[TB] FAIL stall_drain: got valid=%b pkt=%0d expected 0 3", bus.out_valid, pkt_cnt);
        end
    endtask

    task automatic test_orphan();
        fifo_q.push_back(mk_flit(2'b01, 62'hDEAD));
        fifo_q.push_back(mk_flit(2'b11, 62'hBEEF));
        repeat (4) applyStimulus(1'b1);
        total++;
        if (err_cnt !== 4'd1 || pkt_cnt !== 4'd4) begin
            bad++;
            $display("[TB] FAIL orphan_counts: got err=%0d pkt=%0d expected 1 4", err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_trunc();
        fifo_q.push_back(mk_flit(2'b10, 62'h1));
        fifo_q.push_back(mk_flit(2'b00, 62'h2));
        fifo_q.push_back(mk_flit(2'b10, 62'h3));
        repeat (5) applyStimulus(1'b1);
        total++;
        if (err_cnt !== 4'd2 || pkt_cnt !== 4'd4) begin
            bad++;
            $display("[TB] FAIL trunc_counts: got err=%0d pkt=%0d expected 2 4", err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        for (int i = 0; i < 3; i++) fifo_q.push_back(mk_flit(2'b00, 62'h70 + 62'(i)));
        repeat (2) applyStimulus(1'b0);
        do_reset();
        total++;
        if (bus.out_valid !== 1'b0 || pkt_cnt !== '0 || err_cnt !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset: got valid=%b pkt=%0d err=%0d expected 0 0 0",
                     bus.out_valid, pkt_cnt, err_cnt);
        end
        repeat (3) applyStimulus(1'b1);
        total++;
        if (err_cnt !== 4'd1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_orphan: got err=%0d valid=%b expected 1 0", err_cnt, bus.out_valid);
        end
    endtask

    // Random flit types, FIFO gaps and backpressure; also drives counters past wrap/saturation.
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0)
                fifo_q.push_back({$urandom, $urandom});
            applyStimulus($urandom_range(0, 3) != 0);
        end
        while (fifo_q.size() > 0 || m_buf.size() > 0) applyStimulus(1'b1);
        applyStimulus(1'b1);
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_headtail();
        test_packet();
        test_back_to_back_stall();
        test_orphan();
        test_trunc();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
